mc_ctrl: RTL

Multi-cycle sequencing controller for the RISC-V datapath. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB over a shared, handshaked instruction/data memory. It issues the per-cycle enables (PC, IR, register file, memory) that the single-cycle decoder's static signals are qualified with. It traps on unsupported opcodes.

---
 rtl/mc_ctrl_if.sv | 30 +++
 rtl/mc_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/mc_ctrl_if.sv
// Handshake/enable bundle between the multi-cycle sequencer and the datapath/memory.
// The controller side uses the master modport; the datapath/memory side uses slave.
interface mc_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [6:0]       Op;
   logic             mem_ready;
   logic             PCWrite;
   logic             IRWrite;
   logic             RegWrite;
   logic             MemRead;
   logic             MemWrite;
   logic             IorD;
   logic [2:0]       State;
   logic             Illegal;
   logic [CNT_W-1:0] CycleCnt;
   logic [CNT_W-1:0] InstrCnt;

   modport master (
      input  Op, mem_ready,
      output PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD,
      output State, Illegal, CycleCnt, InstrCnt
   );

   modport slave (
      output Op, mem_ready,
      input  PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD,
      input  State, Illegal, CycleCnt, InstrCnt
   );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with trap on unsupported opcodes.
// Optional performance counters are built only when MC_PERF_CNT_EN is defined.
module mc_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic      clk,
   input  logic      rst,
   mc_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd7
   } state_t;

   typedef enum logic [3:0] {
      C_NONE, C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_ILL
   } op_cls_t;

   state_t  state_q, state_d;
   op_cls_t op_q, op_d;
   logic    mem_read_q, mem_write_q, iord_q, reg_write_q, pc_write_q, illegal_q;
   logic    store_done, pc_write;

   function automatic op_cls_t classify(input logic [6:0] op);
      case (op)
         7'b0110011: classify = C_R;
         7'b0010011: classify = C_IALU;
         7'b0000011: classify = C_LOAD;
         7'b0100011: classify = C_STORE;
         7'b1100011: classify = C_BRANCH;
         7'b1101111: classify = C_JAL;
         7'b1100111: classify = C_JALR;
         7'b0110111: classify = C_LUI;
         default:    classify = C_ILL;
      endcase
   endfunction

   function automatic state_t next_state(input state_t s, input op_cls_t cls,
                                         input logic rdy);
      case (s)
         S_FETCH:  next_state = rdy ? S_DECODE : S_FETCH;
         S_DECODE: next_state = (cls == C_ILL) ? S_TRAP : S_EXEC;
         S_EXEC: begin
            if (cls == C_BRANCH)                       next_state = S_FETCH;
            else if (cls == C_LOAD || cls == C_STORE)  next_state = S_MEM;
            else                                       next_state = S_WB;
         end
         S_MEM:    next_state = !rdy ? S_MEM : ((cls == C_LOAD) ? S_WB : S_FETCH);
         S_WB:     next_state = S_FETCH;
         S_TRAP:   next_state = S_TRAP;
         default:  next_state = S_FETCH;
      endcase
   endfunction

   // Op is only looked at in DECODE; its class is then held in op_q for the rest of the instruction
   assign op_d    = (state_q == S_DECODE) ? classify(bus.Op) : op_q;
   assign state_d = next_state(state_q, op_d, bus.mem_ready);

   // Moore enables are registered from the state being entered
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_FETCH;
         op_q        <= C_NONE;
         mem_read_q  <= 1'b1;
         mem_write_q <= 1'b0;
         iord_q      <= 1'b0;
         reg_write_q <= 1'b0;
         pc_write_q  <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         mem_read_q  <= (state_d == S_FETCH) || (state_d == S_MEM && op_d == C_LOAD);
         mem_write_q <= (state_d == S_MEM) && (op_d == C_STORE);
         iord_q      <= (state_d == S_MEM);
         reg_write_q <= (state_d == S_WB);
         pc_write_q  <= (state_d == S_WB) || (state_d == S_EXEC && op_d == C_BRANCH);
         illegal_q   <= (state_d == S_TRAP);
      end
   end

   // IR capture and store retirement follow mem_ready in the same cycle
   assign store_done = (state_q == S_MEM) && (op_q == C_STORE) && bus.mem_ready;
   assign pc_write   = pc_write_q | store_done;

   assign bus.IRWrite  = (state_q == S_FETCH) && bus.mem_ready;
   assign bus.PCWrite  = pc_write;
   assign bus.RegWrite = reg_write_q;
   assign bus.MemRead  = mem_read_q;
   assign bus.MemWrite = mem_write_q;
   assign bus.IorD     = iord_q;
   assign bus.State    = state_q;
   assign bus.Illegal  = illegal_q;

`ifdef MC_PERF_CNT_EN
   logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt_q <= '0;
         instr_cnt_q <= '0;
      end else begin
         cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
         if (pc_write) instr_cnt_q <= instr_cnt_q + CNT_W'(1);
      end
   end

   assign bus.CycleCnt = cycle_cnt_q;
   assign bus.InstrCnt = instr_cnt_q;
`else
   assign bus.CycleCnt = {CNT_W{1'b0}};
   assign bus.InstrCnt = {CNT_W{1'b0}};
`endif

endmodule
